// File: rtl/output_buffer_if.sv
// Output buffer interface: digit writes from the execute stage, halt level,
// FWFT read port and status (count/full/done/overflow).
// Ports: master = producer/consumer side, slave = the buffer itself.
interface output_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2:0]    reg_out;
    logic          out_valid;
    logic          halt;
    logic          rd_ready;
    logic [2:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          done;
    logic          overflow;

    modport master (
        output reg_out, out_valid, halt, rd_ready,
        input  rd_data, rd_valid, count, full, done, overflow
    );

    modport slave (
        input  reg_out, out_valid, halt, rd_ready,
        output rd_data, rd_valid, count, full, done, overflow
    );
endinterface

// File: rtl/output_buffer.sv
// Output digit FIFO with RUN/DRAIN/DONE halt tracking, first-word fall-through.
// Ports: clk, rst (sync, active-high), bus (output_buffer_if.slave).
// Macro OUTPUT_BUFFER_OVERFLOW_EN builds the sticky overflow flag;
// without it overflow is tied low (dropping still happens).
module output_buffer #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    output_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [2:0]    mem [DEPTH];

    logic is_full;
    logic is_empty;
    logic push;
    logic pop;

    always_comb begin
        is_full  = (cnt == CW'(DEPTH));
        is_empty = (cnt == '0);
        pop      = !is_empty && bus.rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push     = bus.out_valid && (state == RUN) && (!is_full || pop);
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; rd_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.reg_out;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (bus.halt) state_nxt = DRAIN;
            DRAIN:   if (is_empty) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

`ifdef OUTPUT_BUFFER_OVERFLOW_EN
    logic ovf;
    logic drop;

    always_comb begin
        drop = bus.out_valid && (state == RUN) && is_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst)       ovf <= 1'b0;
        else if (drop) ovf <= 1'b1;
    end

    assign bus.overflow = ovf;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.rd_data  = mem[rd_ptr];
    assign bus.rd_valid = !is_empty;
    assign bus.count    = cnt;
    assign bus.full     = is_full;
    assign bus.done     = (state == DONE);
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 8, SHALL set the FIFO entry count; legal values are powers of two from 2 to 16.
REQ-003 Port clk, input, 1: rising-edge clock shared with the execute stage.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port reg_out, input, 3: output digit from the execute stage.
REQ-006 Port out_valid, input, 1: reg_out is valid this cycle, one pulse per output instruction.
REQ-007 Port halt, input, 1: execute stage has halted; level, stays high once asserted.
REQ-008 Port rd_ready, input, 1: consumer accepts the head digit this cycle.
REQ-009 Port rd_data, output, 3: head digit, first-word fall-through.
REQ-010 Port rd_valid, output, 1: rd_data holds a valid digit.
REQ-011 Port count, output, log2(DEPTH)+1: number of stored digits.
REQ-012 Port full, output, 1: count equals DEPTH.
REQ-013 Port done, output, 1: halt has been seen and every accepted digit has been read.
REQ-014 Port overflow, output, 1: sticky flag; one or more digits were dropped.

Function
REQ-015 The write pointer and read pointer SHALL each be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-016 Push SHALL occur when out_valid=1, the state is RUN, and either full=0 or a pop occurs in the same cycle.
REQ-017 Pop SHALL occur when rd_valid=1 and rd_ready=1.
REQ-018 rd_valid SHALL equal (count != 0), and rd_data SHALL equal mem[rd_ptr] combinationally.
REQ-019 A digit pushed in cycle N SHALL appear on rd_data/rd_valid in cycle N+1 when the FIFO was empty.
REQ-020 A simultaneous push and pop SHALL leave count unchanged, including when the FIFO is full or holds one entry.
REQ-021 A push attempt with full=1 and no pop SHALL drop the digit, leave the pointers unchanged, and set overflow in the next cycle.
REQ-022 A pop with count=0 SHALL be impossible; rd_ready while empty SHALL have no effect.
REQ-023 The FSM SHALL have states RUN, DRAIN and DONE.
REQ-024 From RUN, halt=1 SHALL move to DRAIN; an out_valid asserted in that same cycle SHALL still be pushed.
REQ-025 In DRAIN and DONE, out_valid SHALL be ignored and SHALL NOT set overflow.
REQ-026 From DRAIN, the FSM SHALL move to DONE in the cycle after count reaches 0; done is high only in DONE.
REQ-027 DONE SHALL be terminal until reset.
REQ-028 A halt seen with an empty FIFO SHALL assert done exactly 2 cycles after the halt cycle.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL apply: pointers=0, count=0, state=RUN, overflow=0, done=0, full=0, rd_valid=0.
REQ-030 Memory contents SHALL NOT be reset; rd_data is don't-care while rd_valid=0.
REQ-031 Reset SHALL take priority over push, pop and FSM transitions, including mid-drain.

Configuration
REQ-032 Macro OUTPUT_BUFFER_OVERFLOW_EN defined: overflow SHALL behave per REQ-014 and REQ-021.
REQ-033 Macro OUTPUT_BUFFER_OVERFLOW_EN undefined: overflow SHALL be tied to 0 and no sticky register is built; drop behaviour is unchanged.

Verification
REQ-034 The bench SHALL cover push-then-read: after reset, push 5 then 3 with rd_ready=0; the next cycle gives count=2, rd_data=5. Then rd_ready=1 for 2 cycles reads 5, 3, after which rd_valid=0.
REQ-035 The bench SHALL cover overflow with DEPTH=8: push 9 digits 0..7,1 with no reads, giving full=1, count=8 and overflow=1. Reading all 8 returns 0..7.
REQ-036 The bench SHALL cover push and pop while full: at full with rd_ready=1, push 6; count stays 8, overflow stays 0, and 6 is read last.
REQ-037 The bench SHALL cover halt with a pending digit: out_valid=1 with digit 4 and halt=1 in the same cycle; digit 4 is stored and the state is DRAIN. After one pop, done=1 the cycle after empty.
REQ-038 The bench SHALL cover halt while empty and post-halt writes: halt=1 with count=0 gives done=1 2 cycles later. Then out_valid=1 with digit 7 leaves count=0 and overflow=0.
REQ-039 The bench SHALL cover reset mid-drain: in DRAIN with count=3, asserting rst for 1 cycle gives count=0, done=0, state RUN. A following push of 2 is readable next cycle.
